// File: rtl/aes_req_scheduler_if.sv
// Requester/core-facing bundle of the AES request scheduler.
// The master side is the environment (requesters plus core); the slave side is the scheduler.
interface aes_req_scheduler_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic             en;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_state;
  logic [N*128-1:0] req_key;
  logic [127:0]     aes_state;
  logic [127:0]     aes_key;
  logic [127:0]     aes_out;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [127:0]     rsp_data;
  logic             busy;

  modport master (
    output en, req_valid, req_state, req_key, aes_out,
    input  req_ready, aes_state, aes_key, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  en, req_valid, req_state, req_key, aes_out,
    output req_ready, aes_state, aes_key, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler sharing one pipelined AES-128 core among N requesters.
// Requester IDs travel in a tag pipe matched to the core latency and tag the returned ciphertext.
module aes_req_scheduler #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 21
) (
  input logic                 clk,
  input logic                 rst,
  aes_req_scheduler_if.slave  bus
);

  logic [IDW-1:0] ptr_r;
  logic [N-1:0]   grant_s;
  logic [IDW-1:0] grant_id_s;
  logic           grant_any_s;

  logic [127:0]   aes_state_r;
  logic [127:0]   aes_key_r;
  logic [LATENCY-1:0] tag_v_r;
  logic [IDW-1:0] tag_id_r [LATENCY];
  logic           rsp_valid_r;
  logic [IDW-1:0] rsp_id_r;
  logic           busy_r;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_s     = '0;
    grant_id_s  = '0;
    grant_any_s = 1'b0;
    if (bus.en && !rst) begin
      for (int k = 1; k <= N; k++) begin
        if (!grant_any_s && bus.req_valid[(int'(ptr_r) + k) % N]) begin
          grant_any_s = 1'b1;
          grant_s[(int'(ptr_r) + k) % N] = 1'b1;
          grant_id_s  = IDW'((int'(ptr_r) + k) % N);
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // Core operand registers, RR pointer, and the ID tag pipe; the last tag stage drives the
  // registered response, so a block presented in cycle c is reported in cycle c+LATENCY.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= IDW'(N - 1);
      aes_state_r <= 128'd0;
      aes_key_r   <= 128'd0;
      tag_v_r     <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_id_r[k] <= '0;
      end
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      busy_r      <= 1'b0;
    end else begin
      if (grant_any_s) begin
        aes_state_r <= bus.req_state[int'(grant_id_s)*128 +: 128];
        aes_key_r   <= bus.req_key[int'(grant_id_s)*128 +: 128];
        ptr_r       <= grant_id_s;
      end else begin
        aes_state_r <= aes_state_r;
        aes_key_r   <= aes_key_r;
        ptr_r       <= ptr_r;
      end
      tag_v_r     <= {tag_v_r[LATENCY-2:0], grant_any_s};
      tag_id_r[0] <= grant_id_s;
      for (int k = 1; k < LATENCY; k++) begin
        tag_id_r[k] <= tag_id_r[k-1];
      end
      rsp_valid_r <= tag_v_r[LATENCY-1];
      if (tag_v_r[LATENCY-1]) begin
        rsp_id_r <= tag_id_r[LATENCY-1];
      end else begin
        rsp_id_r <= rsp_id_r;
      end
      // Next-cycle occupancy: new accept, or any tag still in the pipe or about to be reported.
      busy_r <= grant_any_s | (|tag_v_r);
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.aes_state = aes_state_r;
  assign bus.aes_key   = aes_key_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = bus.aes_out;
  assign bus.busy      = busy_r;

endmodule
